// File: rtl/move_scheduler.sv
// Arbitrates robot moves against obstacle moves with bounded wait fairness
// and a finite obstacle budget. All outputs are registered strobes.
module move_scheduler #(
  parameter int K        = 2,
  parameter int MAX_WAIT = 3,
  parameter int BUDGET   = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       robot_req,
  input  logic [3:0] obs_req,
  input  logic       error_in,
  output logic       move_robot,
  output logic       move_obs1_up,
  output logic       move_obs1_down,
  output logic       move_obs1_left,
  output logic       move_obs1_right,
  output logic [5:0] obs_budget,
  output logic       halted
);

  typedef enum logic [1:0] {START, RUN, HALT} state_t;

  localparam logic [2:0] MW  = 3'(MAX_WAIT);
  localparam logic [5:0] BUD = 6'(BUDGET);

  state_t     r_state;
  logic [2:0] r_wait_r;
  logic [2:0] r_wait_o;
  logic [5:0] r_budget;
  logic       r_move_robot;
  logic       r_up;
  logic       r_down;
  logic       r_left;
  logic       r_right;
  logic       r_halted;

  logic       w_robot_vld;
  logic       w_obs_vld;
  logic       w_grant_r;
  logic       w_grant_o;
  logic [2:0] w_wait_r_nxt;
  logic [2:0] w_wait_o_nxt;
  logic       w_unused_k;

  // K only mirrors the planning stage's parameter list.
  assign w_unused_k = (K != 0);

  function automatic logic [2:0] wait_next(input logic granted, input logic valid,
                                           input logic [2:0] cur);
    if (granted || !valid) return 3'd0;
    if (cur >= MW) return MW;
    return cur + 3'd1;
  endfunction

  assign w_robot_vld = robot_req;
  assign w_obs_vld   = (obs_req != 4'd0) && (r_budget != 6'd0);

  // A side that has waited MAX_WAIT cycles is served first; ties favour the robot.
  always_comb begin
    w_grant_r = 1'b0;
    w_grant_o = 1'b0;
    if (w_robot_vld && w_obs_vld) begin
      if (r_wait_r == MW)            w_grant_r = 1'b1;
      else if (r_wait_o == MW)       w_grant_o = 1'b1;
      else if (r_wait_o > r_wait_r)  w_grant_o = 1'b1;
      else                           w_grant_r = 1'b1;
    end else begin
      w_grant_r = w_robot_vld;
      w_grant_o = w_obs_vld;
    end
  end

  assign w_wait_r_nxt = wait_next(w_grant_r, w_robot_vld, r_wait_r);
  assign w_wait_o_nxt = wait_next(w_grant_o, w_obs_vld, r_wait_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= START;
      r_wait_r     <= 3'd0;
      r_wait_o     <= 3'd0;
      r_budget     <= BUD;
      r_move_robot <= 1'b0;
      r_up         <= 1'b0;
      r_down       <= 1'b0;
      r_left       <= 1'b0;
      r_right      <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_move_robot <= 1'b0;
      r_up         <= 1'b0;
      r_down       <= 1'b0;
      r_left       <= 1'b0;
      r_right      <= 1'b0;
      case (r_state)
        START: r_state <= RUN;
        RUN: begin
          if (error_in) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else begin
            r_wait_r     <= w_wait_r_nxt;
            r_wait_o     <= w_wait_o_nxt;
            r_move_robot <= w_grant_r;
            // Up beats down and left beats right when both are requested.
            r_up         <= w_grant_o & obs_req[3];
            r_down       <= w_grant_o & ~obs_req[3] & obs_req[2];
            r_left       <= w_grant_o & obs_req[1];
            r_right      <= w_grant_o & ~obs_req[1] & obs_req[0];
            if (w_grant_o) r_budget <= r_budget - 6'd1;
          end
        end
        HALT:    r_state <= HALT;
        default: r_state <= START;
      endcase
    end
  end

  assign move_robot      = r_move_robot;
  assign move_obs1_up    = r_up;
  assign move_obs1_down  = r_down;
  assign move_obs1_left  = r_left;
  assign move_obs1_right = r_right;
  assign obs_budget      = r_budget;
  assign halted          = r_halted;

endmodule
